imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Hardware loader that fills the Pipeline_CPU instruction memory from a byte stream and holds the CPU in reset until the program is in place. It replaces the simulation-only `$readmemb` load with a synthesizable path. It sits between an external byte source (UART receiver or host FIFO) and the instruction-memory write port, and drives the CPU's `rst_n`.

## Interface
- `DEPTH`, default 32: instruction-memory depth in 32-bit words; the largest accepted program length.
- `ADDR_W`, default 32: width of `im_addr_o`, a byte address matching the PC width.

Ports:
- `clk_i`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `byte_i`  in  8  incoming stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid this cycle.
- `byte_ready_o`  out  1  the loader accepts a byte this cycle.
- `im_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr_o`  out  ADDR_W  word-aligned byte address, equal to 4 × word index.
- `im_data_o`  out  32  assembled instruction word.
- `cpu_rst_n_o`  out  1  active-low reset to Pipeline_CPU; low until the load completes.
- `done_o`  out  1  load completed successfully; sticky.
- `err_o`  out  1  length error; sticky.

## Operation
- **Stream format.** A 16-bit word count N (high byte first), then N words of 4 bytes each, most significant byte first.
- **Transfer rule.** A byte is transferred on a rising edge where `byte_valid_i && byte_ready_o`. `byte_ready_o` is combinational from state: 1 in LEN_HI, LEN_LO and DATA; 0 otherwise.
- **FSM states.**
  - LEN_HI: on transfer, latch `len[15:8]`, go to LEN_LO.
  - LEN_LO: on transfer, form `len`.
    - `len == 0`: go to DONE.
    - `len > DEPTH`: go to ERR.
    - Otherwise: go to DATA with `widx = 0` and `bcnt = 0`.
  - DATA: on each transfer, shift the byte into a 32-bit assembly register (`asm = {asm[23:0], byte_i}`) and increment `bcnt` (2 bits, wraps).
    - On the transfer with `bcnt == 3`, register `im_data_o = {asm[23:0], byte_i}`, `im_addr_o = widx << 2` and `im_we_o = 1`, then increment `widx`.
    - If that word is the last (`widx == len-1`), go to DONE.
  - DONE: `byte_ready_o = 0`; holds until `rst_n`.
  - ERR: `byte_ready_o = 0`; `cpu_rst_n_o` stays 0; holds until `rst_n`.
- **Stalls.** `byte_valid_i` low stalls the FSM indefinitely with no timeout. Bytes offered in DONE or ERR are not accepted.
- **Widths.** `widx` and `len` are 16 bits. `im_addr_o` is `widx` zero-extended and shifted left by 2; the top address is `4*(DEPTH-1)`.
- **Reset mid-operation.** Everything returns to LEN_HI and a partial word is discarded. Instruction-memory contents already written are not cleared; a reload overwrites them.

## Timing
- **Reset values** (after any edge with `rst_n = 0`): `byte_ready_o = 0`, `im_we_o = 0`, `im_addr_o = 0`, `im_data_o = 0`, `cpu_rst_n_o = 0`, `done_o = 0`, `err_o = 0`. State is LEN_HI.
- **Ready after reset.** `byte_ready_o` rises in the first cycle with `rst_n = 1`.
- **Word write.** If the 4th byte of word n transfers at edge k:
  - `im_we_o`, `im_addr_o` and `im_data_o` are valid during cycle k→k+1.
  - Memory captures at edge k+1.
  - `im_we_o` is a single-cycle pulse, dropping at edge k+1 unless another word completes at k+1.
  - `im_addr_o` and `im_data_o` hold their last values between writes.
- **Back-to-back.** The loader accepts one byte per cycle, giving at most one `im_we_o` pulse every 4 cycles. It can accept a byte in the same cycle `im_we_o` is high.
- **Completion.**
  - Last word completes at edge k: `done_o` and `cpu_rst_n_o` rise at edge k+1, one cycle after the final write strobe, so the CPU never fetches before the last word is written.
  - `len == 0` accepted at edge k: `done_o` and `cpu_rst_n_o` rise at edge k+1.
- **Error.** Bad length accepted at edge k: `err_o` rises at edge k+1 and `cpu_rst_n_o` stays 0.
- **Latency.** Total from the first length byte to `cpu_rst_n_o = 1` is (2 + 4N) accepted bytes plus 1 cycle.

## Test plan
- **Minimal load.** Stream `00 01 20 01 00 05` with valid held high → one `im_we_o` pulse with addr 0, data 0x20010005. `cpu_rst_n_o` and `done_o` rise 1 cycle after the pulse; `byte_ready_o` then stays 0.
- **Full depth, with stalls.** N=32 words of `0x1000_0000 + i`, with `byte_valid_i` deasserted on random cycles → 32 pulses at addresses 0, 4, …, 124 with matching data; no pulse during stalls; `done_o` only after the 32nd pulse.
- **Over-length.** Length `00 21` (33) → `err_o` = 1, `cpu_rst_n_o` stays 0, `byte_ready_o` = 0, no `im_we_o` pulses; subsequent valid bytes are ignored.
- **Zero length.** Length `00 00` → `done_o` and `cpu_rst_n_o` = 1 one cycle later, no writes.
- **Reset mid-operation.** `rst_n` pulsed low after 2 bytes of word 1 of a 3-word load → all outputs return to reset values. A fresh 1-word stream `00 01 DE AD BE EF` then writes 0xDEADBEEF at addr 0 and completes.
- **End-to-end.** Load the CO_P6_test_1 program through the loader into Pipeline_CPU and run 30 cycles after `cpu_rst_n_o` rises → register-file and data-memory contents identical to the `$readmemb`-loaded run.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed byte stream into 32-bit words, writes
// them to instruction memory and releases the CPU reset once the program is loaded.
module imem_boot_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_data_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [15:0]         len_full;
  logic                word_last;
  logic [ADDR_W-1:0]   word_addr;

  assign xfer      = byte_valid_i && byte_ready_o;
  assign len_full  = {len_q[15:8], byte_i};
  assign word_last = (bcnt_q == 2'd3) && (widx_q == len_q - 16'd1);
  assign word_addr = ADDR_W'({widx_q, 2'b00});

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= S_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_HI: begin
        if (xfer) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)        state_d = S_DONE;
          else if (len_full > DEPTH_W)  state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && word_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN_HI;
    endcase
  end

  // Outputs: ready is masked while reset is held so no byte is lost to a reset edge
  always_comb begin
    byte_ready_o = rst_n && ((state_q == S_LEN_HI) ||
                             (state_q == S_LEN_LO) ||
                             (state_q == S_DATA));
    im_we_o      = we_q;
    im_addr_o    = addr_q;
    im_data_o    = data_q;
    done_o       = done_q;
    err_o        = err_q;
    cpu_rst_n_o  = done_q;
  end

  // Datapath next-state
  always_comb begin
    len_d  = len_q;
    widx_d = widx_q;
    bcnt_d = bcnt_q;
    asm_d  = asm_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      S_LEN_HI: begin
        if (xfer) len_d = {byte_i, len_q[7:0]};
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d  = len_full;
          widx_d = 16'd0;
          bcnt_d = 2'd0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d  = {asm_q[15:0], byte_i};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = {asm_q, byte_i};
            addr_d = word_addr;
            widx_d = widx_q + 16'd1;
          end
        end
      end
      default: begin
      end
    endcase
    // Delayed one cycle behind the state so the CPU wakes after the last strobe
    done_d = (state_q == S_DONE);
    err_d  = (state_q == S_ERR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      len_q  <= 16'd0;
      widx_q <= 16'd0;
      bcnt_q <= 2'd0;
      asm_q  <= 24'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= 32'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      widx_q <= widx_d;
      bcnt_q <= bcnt_d;
      asm_q  <= asm_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: cycle vector table, randomized loads against a
// word-list model, and a reset-during-load sequence.
module tb_imem_boot_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              im_we_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_data_o;
  logic              cpu_rst_n_o;
  logic              done_o;
  logic              err_o;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_data_o    (im_data_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  b;
    logic        vld;
    logic        chk;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        cpu;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] prog [DEPTH];

  function automatic vec_t mk(input logic rst, input logic [7:0] b, input logic vld,
                              input logic chk, input logic rdy, input logic we,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic done, input logic err, input logic cpu);
    vec_t v;
    v.rst = rst; v.b = b; v.vld = vld; v.chk = chk; v.rdy = rdy; v.we = we;
    v.addr = addr; v.data = data; v.done = done; v.err = err; v.cpu = cpu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    check({tag, "_we"},    {31'd0, im_we_o},      32'd0);
    check({tag, "_addr"},  im_addr_o,             32'd0);
    check({tag, "_data"},  im_data_o,             32'd0);
    check({tag, "_done"},  {31'd0, done_o},       32'd0);
    check({tag, "_err"},   {31'd0, err_o},        32'd0);
    check({tag, "_cpu"},   {31'd0, cpu_rst_n_o},  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
  endtask

  // Model: the stream is N (16b, MSB first) then prog words MSB first; word i lands at 4*i.
  task automatic run_load(input int n, input int stall_pct);
    logic [7:0]  stream [$];
    logic [15:0] n16;
    int idx = 0, cyc = 0, exp_i = 0, last_we = -10, after = 0;
    bit done_seen = 0;
    n16 = n[15:0];
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      stream.push_back(prog[i][31:24]);
      stream.push_back(prog[i][23:16]);
      stream.push_back(prog[i][15:8]);
      stream.push_back(prog[i][7:0]);
    end
    while (cyc < 3000 && after < 3) begin
      @(negedge clk);
      rst_n = 1'b1;
      byte_valid_i = (idx < stream.size()) && (int'($urandom_range(99)) >= stall_pct);
      byte_i = (idx < stream.size()) ? stream[idx] : 8'h00;
      #1;
      if (im_we_o) begin
        if (exp_i >= n) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_we: got write addr %h beyond required %0d words", im_addr_o, n);
        end else begin
          $display("write %0d addr=%h data=%h", exp_i, im_addr_o, im_data_o);
          check("we_addr", im_addr_o, 32'(exp_i * 4));
          check("we_data", im_data_o, prog[exp_i]);
          check("we_gap", (cyc - last_we >= 4) ? 32'd1 : 32'd0, 32'd1);
        end
        exp_i++;
        last_we = cyc;
      end
      if (!done_seen) begin
        if (done_o) begin
          done_seen = 1;
          check("done_count", 32'(exp_i), 32'(n));
          check("done_delay", 32'(cyc - last_we), 32'd1);
          check("done_cpu", {31'd0, cpu_rst_n_o}, 32'd1);
        end else if (cpu_rst_n_o !== 1'b0) begin
          check("cpu_early", {31'd0, cpu_rst_n_o}, 32'd0);
        end
      end else begin
        after++;
      end
      if (byte_valid_i && byte_ready_o) idx++;
      cyc++;
    end
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got no done after %0d cycles, required done for %0d words", cyc, n);
    end
    check("post_ready", {31'd0, byte_ready_o}, 32'd0);
    check("post_err",   {31'd0, err_o},        32'd0);
    check("post_bytes", 32'(idx), 32'(2 + 4 * n));
    byte_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = mk(1, 8'h00, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[1]  = mk(1, 8'h01, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[2]  = mk(1, 8'h20, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[3]  = mk(1, 8'h01, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[4]  = mk(1, 8'h00, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[5]  = mk(1, 8'h05, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[6]  = mk(1, 8'h00, 1, 1, 0, 1, 0, 32'h20010005, 0, 0, 0);
    vecs[7]  = mk(1, 8'h00, 1, 1, 0, 0, 0, 32'h20010005, 1, 0, 1);
    vecs[8]  = mk(1, 8'hAA, 1, 1, 0, 0, 0, 32'h20010005, 1, 0, 1);
    vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[10] = mk(1, 8'h00, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[11] = mk(1, 8'h00, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[12] = mk(1, 8'h00, 1, 1, 0, 0, 0, 0,            0, 0, 0);
    vecs[13] = mk(1, 8'h00, 1, 1, 0, 0, 0, 0,            1, 0, 1);
    vecs[14] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[15] = mk(1, 8'h00, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[16] = mk(1, 8'h21, 1, 1, 1, 0, 0, 0,            0, 0, 0);
    vecs[17] = mk(1, 8'h55, 1, 1, 0, 0, 0, 0,            0, 0, 0);
    vecs[18] = mk(1, 8'h66, 1, 1, 0, 0, 0, 0,            0, 1, 0);
    vecs[19] = mk(1, 8'h77, 1, 1, 0, 0, 0, 0,            0, 1, 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n        = vecs[i].rst;
      byte_i       = vecs[i].b;
      byte_valid_i = vecs[i].vld;
      #1;
      if (vecs[i].chk) begin
        $display("vec %0d byte=%h rdy=%b we=%b addr=%h data=%h done=%b err=%b cpu=%b",
                 i, byte_i, byte_ready_o, im_we_o, im_addr_o, im_data_o, done_o, err_o, cpu_rst_n_o);
        check($sformatf("vec%0d_ready", i), {31'd0, byte_ready_o}, {31'd0, vecs[i].rdy});
        check($sformatf("vec%0d_we", i),    {31'd0, im_we_o},      {31'd0, vecs[i].we});
        check($sformatf("vec%0d_addr", i),  im_addr_o,             vecs[i].addr);
        check($sformatf("vec%0d_data", i),  im_data_o,             vecs[i].data);
        check($sformatf("vec%0d_done", i),  {31'd0, done_o},       {31'd0, vecs[i].done});
        check($sformatf("vec%0d_err", i),   {31'd0, err_o},        {31'd0, vecs[i].err});
        check($sformatf("vec%0d_cpu", i),   {31'd0, cpu_rst_n_o},  {31'd0, vecs[i].cpu});
      end
    end

    // Full depth with stalls, then random-length random-content loads
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'h1000_0000 + 32'(i);
    do_reset();
    $display("load n=%0d stalls", DEPTH);
    run_load(DEPTH, 30);
    for (int t = 0; t < 5; t++) begin
      n = (t == 0) ? 1 : int'($urandom_range(DEPTH, 1));
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      do_reset();
      $display("load n=%0d random", n);
      run_load(n, int'($urandom_range(50)));
    end

    // Reset after two bytes of word 1 of a 3-word load
    do_reset();
    begin
      logic [7:0] pre [8];
      pre[0] = 8'h00; pre[1] = 8'h03;
      pre[2] = 8'h11; pre[3] = 8'h22; pre[4] = 8'h33; pre[5] = 8'h44;
      pre[6] = 8'h55; pre[7] = 8'h66;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        rst_n = 1'b1;
        byte_i = pre[i];
        byte_valid_i = 1'b1;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    $display("mid-load reset");
    check_reset_outputs("midrst");
    prog[0] = 32'hDEADBEEF;
    $display("load n=1 after mid-load reset");
    run_load(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation time limit, required completion");
    $fatal(1, "timeout");
  end
endmodule
